// File: rtl/dmem_ctrl_if.sv
// Request/response bus between a load/store unit and dmem_ctrl.
// master: requester (drives REQ_*, receives REQ_READY and RSP_*).
// slave : dmem_ctrl (receives REQ_*, drives REQ_READY and RSP_*).
interface dmem_ctrl_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic [1:0]  REQ_SIZE;
  logic        REQ_UNSIGNED;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;

  modport master (
    output REQ_VALID, REQ_WE, REQ_SIZE, REQ_UNSIGNED, REQ_ADDR, REQ_WDATA,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR
  );

  modport slave (
    input  REQ_VALID, REQ_WE, REQ_SIZE, REQ_UNSIGNED, REQ_ADDR, REQ_WDATA,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns byte/half/word load/store requests into
// accesses on a single-port synchronous SRAM with active-low controls.
// Sub-word stores are done as read-modify-write.
// Ports:
//   CLK, RSTN          clock, asynchronous active-low reset
//   bus (slave)        request/response handshake (dmem_ctrl_if)
//   MEM_CSN, MEM_WEN   SRAM chip select / write enable (active low)
//   MEM_A, MEM_DI      SRAM word address / write data
//   MEM_DOUT           SRAM read data, valid the cycle after the read edge
module dmem_ctrl #(
  parameter int unsigned AW = 10
) (
  input  logic          CLK,
  input  logic          RSTN,
  dmem_ctrl_if.slave    bus,
  output logic          MEM_CSN,
  output logic          MEM_WEN,
  output logic [AW-1:0] MEM_A,
  output logic [31:0]   MEM_DI,
  input  logic [31:0]   MEM_DOUT
);

  localparam int unsigned DW = 32;

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RSP} state_e;

  state_e state_q, state_d;

  // Captured request
  logic          we_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [1:0]    lane_q;
  logic [AW-1:0] waddr_q;
  logic [15:0]   wdata_q;

  // Registered outputs
  logic          ready_q,     ready_d;
  logic          csn_q,       csn_d;
  logic          wen_q,       wen_d;
  logic [AW-1:0] mem_a_q,     mem_a_d;
  logic [DW-1:0] mem_di_q,    mem_di_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q,   rsp_err_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;

  logic accept_c;
  logic err_c;

  // Replace the addressed byte or half lane of a word.
  function automatic logic [31:0] merge_f(input logic [31:0] old_w,
                                          input logic [15:0] new_d,
                                          input logic [1:0]  size,
                                          input logic [1:0]  lane);
    logic [31:0] w;
    w = old_w;
    if (size == 2'b00) w[{lane, 3'b000} +: 8] = new_d[7:0];
    else               w[{lane[1], 4'b0000} +: 16] = new_d;
    return w;
  endfunction

  // Right-align the addressed lane and sign/zero-extend it.
  function automatic logic [31:0] extend_f(input logic [31:0] w,
                                           input logic [1:0]  size,
                                           input logic        uns,
                                           input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign accept_c = (state_q == IDLE) && bus.REQ_VALID;

  // Misaligned, reserved size, or address beyond the SRAM.
  always_comb begin
    err_c = 1'b0;
    case (bus.REQ_SIZE)
      2'b00:   err_c = 1'b0;
      2'b01:   err_c = bus.REQ_ADDR[0];
      2'b10:   err_c = |bus.REQ_ADDR[1:0];
      default: err_c = 1'b1;
    endcase
    if ((bus.REQ_ADDR >> (AW + 2)) != 32'd0) err_c = 1'b1;
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d     = state_q;
    ready_d     = 1'b0;
    csn_d       = 1'b1;
    wen_d       = 1'b1;
    mem_a_d     = '0;
    mem_di_d    = '0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;

    case (state_q)
      IDLE: begin
        if (bus.REQ_VALID) begin
          if (err_c)                                    state_d = RSP;
          else if (bus.REQ_WE && bus.REQ_SIZE == 2'b10) state_d = WR;
          else                                          state_d = RD;
        end
      end
      RD:      state_d = WAIT;
      WAIT:    state_d = we_q ? WR : RSP;
      WR:      state_d = RSP;
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);

    if (state_d == RD || state_d == WR) begin
      csn_d   = 1'b0;
      mem_a_d = (state_q == IDLE) ? bus.REQ_ADDR[AW+1:2] : waddr_q;
    end

    // Word stores write straight from the bus; RMW merges the read word.
    if (state_d == WR) begin
      wen_d    = 1'b0;
      mem_di_d = (state_q == IDLE) ? bus.REQ_WDATA
                                   : merge_f(MEM_DOUT, wdata_q, size_q, lane_q);
    end

    // Only an error goes IDLE->RSP; only a load goes WAIT->RSP.
    if (state_d == RSP) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = (state_q == IDLE);
      if (state_q == WAIT) rsp_rdata_d = extend_f(MEM_DOUT, size_q, uns_q, lane_q);
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      csn_q       <= 1'b1;
      wen_q       <= 1'b1;
      mem_a_q     <= '0;
      mem_di_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      csn_q       <= csn_d;
      wen_q       <= wen_d;
      mem_a_q     <= mem_a_d;
      mem_di_q    <= mem_di_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Request capture on accept.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      lane_q  <= 2'b00;
      waddr_q <= '0;
      wdata_q <= '0;
    end else if (accept_c) begin
      we_q    <= bus.REQ_WE;
      size_q  <= bus.REQ_SIZE;
      uns_q   <= bus.REQ_UNSIGNED;
      lane_q  <= bus.REQ_ADDR[1:0];
      waddr_q <= bus.REQ_ADDR[AW+1:2];
      wdata_q <= bus.REQ_WDATA[15:0];
    end
  end

  assign bus.REQ_READY = ready_q;
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_ERR   = rsp_err_q;
  assign bus.RSP_RDATA = rsp_rdata_q;
  assign MEM_CSN       = csn_q;
  assign MEM_WEN       = wen_q;
  assign MEM_A         = mem_a_q;
  assign MEM_DI        = mem_di_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: table of directed requests with hand-computed
// responses, plus sequences for reset mid-RMW and back-to-back requests.
module tb_dmem_ctrl;

  localparam int unsigned AW = 10;

  logic          CLK;
  logic          RSTN;
  logic          MEM_CSN;
  logic          MEM_WEN;
  logic [AW-1:0] MEM_A;
  logic [31:0]   MEM_DI;
  logic [31:0]   MEM_DOUT;

  dmem_ctrl_if bus ();

  dmem_ctrl #(.AW(AW)) dut (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .bus      (bus),
    .MEM_CSN  (MEM_CSN),
    .MEM_WEN  (MEM_WEN),
    .MEM_A    (MEM_A),
    .MEM_DI   (MEM_DI),
    .MEM_DOUT (MEM_DOUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // SRAM model with a preload port used only during reset.
  logic [31:0]   mem [0:(1<<AW)-1];
  logic          pre_we;
  logic [AW-1:0] pre_a;
  logic [31:0]   pre_d;

  always @(posedge CLK) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (!MEM_CSN) begin
      if (!MEM_WEN) mem[MEM_A] <= MEM_DI;
      else          MEM_DOUT   <= mem[MEM_A];
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          ncsn;
    int          nwr;
    int          mem_idx;
    logic [31:0] mem_val;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_req(input int idx);
    vec_t v;
    int   lat, ncsn, nwr;
    bit   got, clean;
    string tag;
    v   = vecs[idx];
    tag = $sformatf("v%0d", idx);
    @(negedge CLK);
    bus.REQ_WE       = v.we;
    bus.REQ_SIZE     = v.size;
    bus.REQ_UNSIGNED = v.uns;
    bus.REQ_ADDR     = v.addr;
    bus.REQ_WDATA    = v.wdata;
    bus.REQ_VALID    = 1'b1;
    check({tag, " ready_before"}, 32'(bus.REQ_READY), 32'd1);
    @(posedge CLK);
    #1;
    bus.REQ_VALID = 1'b0;
    lat = 0; ncsn = 0; nwr = 0; got = 1'b0; clean = 1'b1;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge CLK);
      if (!MEM_CSN) begin
        ncsn++;
        if (!MEM_WEN) nwr++;
        check({tag, " mem_a"}, 32'(MEM_A), 32'(v.addr[AW+1:2]));
      end else if (MEM_WEN !== 1'b1 || MEM_A !== '0 || MEM_DI !== 32'd0) begin
        clean = 1'b0;
      end
      if (bus.RSP_VALID) begin
        got = 1'b1;
        lat = c;
        check({tag, " rsp_err"},   32'(bus.RSP_ERR), 32'(v.err));
        check({tag, " rsp_rdata"}, bus.RSP_RDATA,    v.rdata);
      end else if (bus.RSP_ERR !== 1'b0 || bus.RSP_RDATA !== 32'd0 || bus.REQ_READY !== 1'b0) begin
        clean = 1'b0;
      end
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s timeout: no RSP_VALID within 8 cycles", tag);
    end
    check({tag, " latency"},  32'(lat),   32'(v.lat));
    check({tag, " csn_low"},  32'(ncsn),  32'(v.ncsn));
    check({tag, " writes"},   32'(nwr),   32'(v.nwr));
    check({tag, " idle_out"}, 32'(clean), 32'd1);
    @(negedge CLK);
    check({tag, " pulse_end"}, 32'(bus.RSP_VALID), 32'd0);
    check({tag, " ready_ret"}, 32'(bus.REQ_READY), 32'd1);
    if (v.mem_idx >= 0) check({tag, " mem"}, mem[v.mem_idx], v.mem_val);
  endtask

  int acc_cnt, rsp_cnt, spur;

  initial begin
    //        we    size   uns   addr          wdata         err   rdata         lat ncsn nwr mem  val
    vecs[0]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0005, 32'h0,        1'b0, 32'hFFFF_FFC3, 3, 1, 0, -1, 32'h0};
    vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0005, 32'h0,        1'b0, 32'h0000_00C3, 3, 1, 0, -1, 32'h0};
    vecs[2]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0006, 32'h1234_BEEF, 1'b0, 32'h0,        4, 2, 1,  1, 32'hBEEF_C3D4};
    vecs[3]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0008, 32'h1234_5678, 1'b0, 32'h0,        2, 1, 1,  2, 32'h1234_5678};
    vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0008, 32'h0,        1'b0, 32'h1234_5678, 3, 1, 0, -1, 32'h0};
    vecs[5]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0002, 32'h0,        1'b1, 32'h0,        1, 0, 0, -1, 32'h0};
    vecs[6]  = '{1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0,        1'b1, 32'h0,        1, 0, 0, -1, 32'h0};
    vecs[7]  = '{1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'h0,        1'b1, 32'h0,        1, 0, 0, -1, 32'h0};
    vecs[8]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0006, 32'h0,        1'b0, 32'hFFFF_BEEF, 3, 1, 0, -1, 32'h0};
    vecs[9]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0004, 32'h0,        1'b0, 32'h0000_C3D4, 3, 1, 0, -1, 32'h0};
    vecs[10] = '{1'b1, 2'd0, 1'b0, 32'h0000_0007, 32'hFFFF_FF5A, 1'b0, 32'h0,        4, 2, 1,  1, 32'h5AEF_C3D4};
    vecs[11] = '{1'b0, 2'd0, 1'b0, 32'h0000_0007, 32'h0,        1'b0, 32'h0000_005A, 3, 1, 0, -1, 32'h0};
    vecs[12] = '{1'b0, 2'd2, 1'b1, 32'h0000_0004, 32'h0,        1'b0, 32'h5AEF_C3D4, 3, 1, 0, -1, 32'h0};
    vecs[13] = '{1'b0, 2'd0, 1'b0, 32'h0000_0004, 32'h0,        1'b0, 32'hFFFF_FFD4, 3, 1, 0, -1, 32'h0};
    vecs[14] = '{1'b1, 2'd1, 1'b0, 32'h0000_0003, 32'h0000_1111, 1'b1, 32'h0,        1, 0, 0,  1, 32'h5AEF_C3D4};
    vecs[15] = '{1'b0, 2'd2, 1'b0, 32'h0000_0FFC, 32'h0,        1'b0, 32'h8000_0001, 3, 1, 0, -1, 32'h0};
    vecs[16] = '{1'b1, 2'd0, 1'b0, 32'h8000_0000, 32'h0000_0022, 1'b1, 32'h0,        1, 0, 0, -1, 32'h0};

    RSTN             = 1'b0;
    bus.REQ_VALID    = 1'b0;
    bus.REQ_WE       = 1'b0;
    bus.REQ_SIZE     = 2'b00;
    bus.REQ_UNSIGNED = 1'b0;
    bus.REQ_ADDR     = 32'd0;
    bus.REQ_WDATA    = 32'd0;
    pre_we = 1'b0; pre_a = '0; pre_d = 32'd0;

    // Preload the SRAM while the DUT is held in reset.
    @(negedge CLK);
    pre_we = 1'b1; pre_a = AW'(1);    pre_d = 32'hA1B2_C3D4;
    @(negedge CLK);
    pre_a = AW'(1023); pre_d = 32'h8000_0001;
    @(negedge CLK);
    pre_we = 1'b0;

    check("rst ready",     32'(bus.REQ_READY), 32'd1);
    check("rst rsp_valid", 32'(bus.RSP_VALID), 32'd0);
    check("rst rsp_rdata", bus.RSP_RDATA,      32'd0);
    check("rst rsp_err",   32'(bus.RSP_ERR),   32'd0);
    check("rst csn",       32'(MEM_CSN),       32'd1);
    check("rst wen",       32'(MEM_WEN),       32'd1);
    check("rst mem_a",     32'(MEM_A),         32'd0);
    check("rst mem_di",    MEM_DI,             32'd0);

    @(negedge CLK);
    RSTN = 1'b1;

    for (int i = 0; i < NV; i++) do_req(i);

    // Byte store at 0x4 with reset pulsed during WAIT.
    @(negedge CLK);
    bus.REQ_WE = 1'b1; bus.REQ_SIZE = 2'd0; bus.REQ_UNSIGNED = 1'b0;
    bus.REQ_ADDR = 32'h4; bus.REQ_WDATA = 32'h77; bus.REQ_VALID = 1'b1;
    @(posedge CLK);
    #1;
    bus.REQ_VALID = 1'b0;
    @(negedge CLK);
    check("abort rd_csn", 32'(MEM_CSN), 32'd0);
    @(negedge CLK);
    check("abort wait_csn", 32'(MEM_CSN), 32'd1);
    RSTN = 1'b0;
    #1;
    check("abort ready",     32'(bus.REQ_READY), 32'd1);
    check("abort rsp_valid", 32'(bus.RSP_VALID), 32'd0);
    check("abort csn",       32'(MEM_CSN),       32'd1);
    check("abort wen",       32'(MEM_WEN),       32'd1);
    @(negedge CLK);
    RSTN = 1'b1;
    spur = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (bus.RSP_VALID !== 1'b0 || MEM_CSN !== 1'b1) spur++;
    end
    check("abort quiet", 32'(spur),  32'd0);
    check("abort mem1",  mem[1],     32'h5AEF_C3D4);

    // REQ_VALID held high: load word 0x8 repeatedly, 4 cycles per transaction.
    bus.REQ_WE = 1'b0; bus.REQ_SIZE = 2'd2; bus.REQ_UNSIGNED = 1'b0;
    bus.REQ_ADDR = 32'h8; bus.REQ_WDATA = 32'h0; bus.REQ_VALID = 1'b1;
    acc_cnt = 0; rsp_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (k != 0) @(negedge CLK);
      check($sformatf("hold ready k%0d", k), 32'(bus.REQ_READY), 32'((k % 4) == 0));
      if (bus.REQ_READY && bus.REQ_VALID) acc_cnt++;
      if (bus.RSP_VALID) begin
        rsp_cnt++;
        check($sformatf("hold rdata k%0d", k), bus.RSP_RDATA, 32'h1234_5678);
      end
    end
    bus.REQ_VALID = 1'b0;
    check("hold accepts",   32'(acc_cnt), 32'd4);
    check("hold responses", 32'(rsp_cnt), 32'd4);

    @(negedge CLK);
    @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The block SHALL have parameter AW, default 10, giving the SRAM word-address width.
REQ-002 The block SHALL have port CLK, input, 1 bit: single clock; all state updates on its posedge.
REQ-003 The block SHALL have port RSTN, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port REQ_VALID, input, 1 bit: request present.
REQ-005 The block SHALL have port REQ_READY, output, 1 bit: block can accept a request.
REQ-006 The block SHALL have port REQ_WE, input, 1 bit: 1 = store, 0 = load.
REQ-007 The block SHALL have port REQ_SIZE, input, 2 bits: 00 byte, 01 half, 10 word, 11 reserved.
REQ-008 The block SHALL have port REQ_UNSIGNED, input, 1 bit: zero-extend loads when 1, sign-extend when 0.
REQ-009 The block SHALL have port REQ_ADDR, input, 32 bits: byte address.
REQ-010 The block SHALL have port REQ_WDATA, input, 32 bits: store data, right-aligned.
REQ-011 The block SHALL have port RSP_VALID, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port RSP_RDATA, output, 32 bits: extended load data.
REQ-013 The block SHALL have port RSP_ERR, output, 1 bit: request rejected.
REQ-014 The block SHALL have ports MEM_CSN, MEM_WEN, MEM_A[AW-1:0], MEM_DI[31:0] (outputs) and MEM_DOUT[31:0] (input): active-low single-port synchronous SRAM master; read data is registered in the SRAM, valid the cycle after the read edge.

Function
REQ-015 The block SHALL use states IDLE, RD, WAIT, WR and RSP; REQ_READY=1 only in IDLE.
REQ-016 A request SHALL be accepted and captured on a posedge with REQ_VALID=1 in IDLE; inputs are ignored in all other states.
REQ-017 A request SHALL be an error when REQ_SIZE=11, or half with ADDR[0]=1, or word with ADDR[1:0]!=0, or ADDR[31:AW+2]!=0.
REQ-018 On an error request the block SHALL go IDLE->RSP, never drive MEM_CSN low, and pulse RSP_VALID with RSP_ERR=1 and RSP_RDATA=0 (latency 1).
REQ-019 On a load the block SHALL follow IDLE->RD->WAIT->RSP; in RD MEM_CSN=0, MEM_WEN=1, MEM_A=ADDR[AW+1:2]; MEM_DOUT is captured at the end of WAIT; RSP_VALID is high 3 cycles after the accept edge.
REQ-020 On a word store the block SHALL follow IDLE->WR->RSP; in WR MEM_CSN=0, MEM_WEN=0, MEM_DI=REQ_WDATA (latency 2).
REQ-021 On a byte or half store the block SHALL read-modify-write via IDLE->RD->WAIT->WR->RSP (latency 4), replacing only the addressed lanes of the captured word.
REQ-022 Byte lanes SHALL be little-endian: byte n=ADDR[1:0] occupies bits [8n+7:8n]; a half at ADDR[1]=h occupies bits [16h+15:16h].
REQ-023 Load data SHALL be shifted to bit 0 and extended to 32 bits per REQ_UNSIGNED; word loads ignore REQ_UNSIGNED.
REQ-024 In RSP the block SHALL hold RSP_VALID=1 for exactly one cycle, then return to IDLE; RSP_RDATA=0 for stores and errors.
REQ-025 Outside RD and WR the block SHALL drive MEM_CSN=1, MEM_WEN=1, MEM_A=0 and MEM_DI=0; all outputs SHALL be registered.
REQ-026 RSP_RDATA and RSP_ERR SHALL be 0 whenever RSP_VALID=0.

Reset
REQ-027 While RSTN=0 the block SHALL hold state IDLE, REQ_READY=1, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, MEM_CSN=1, MEM_WEN=1, MEM_A=0 and MEM_DI=0.
REQ-028 Reset asserted mid-operation SHALL abort the request immediately with no response; an RMW aborted before WR SHALL leave memory unchanged.

Verification
REQ-029 Scenario: mem[1]=A1B2C3D4, load byte signed ADDR=0x5 -> RSP 3 cycles after accept, RDATA=FFFFFFC3; unsigned -> 000000C3.
REQ-030 Scenario: mem[1]=A1B2C3D4, store half BEEF at ADDR=0x6 -> one read then one write; mem[1]=BEEFC3D4; RSP 4 cycles after accept, ERR=0.
REQ-031 Scenario: store word 12345678 at ADDR=0x8, then load word at 0x8 -> RDATA=12345678; the store takes exactly one MEM_CSN-low cycle.
REQ-032 Scenario: load word at ADDR=0x2, then size=11, then ADDR=0x1000 with AW=10 -> each gives RSP_ERR=1 after 1 cycle with MEM_CSN held 1.
REQ-033 Scenario: store byte at 0x4 with RSTN pulsed low during WAIT -> outputs return to reset values, no RSP, mem[1] unchanged.
REQ-034 Scenario: REQ_VALID held high continuously -> REQ_READY=0 from accept until the cycle after RSP, and exactly one accept per response.
